// File: rtl/imdct_pkg.sv
// imdct_pkg: shared constants for the IMDCT overlap sequencer.
// Granule geometry, FSM encoding and block-type codes.
package imdct_pkg;

   localparam int NUM_SB = 32;
   localparam int SB_LEN = 18;
   localparam int PAIR_W = 5;
   localparam int IDX_W  = 6;
   localparam int DATA_W = 18;

   localparam logic [1:0] BT_LONG  = 2'b00;
   localparam logic [1:0] BT_SHORT = 2'b10;

   localparam int STATE_W = 3;
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_PAIR = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_CLR_ISSUE = 3'd4;
   localparam logic [2:0] S_CLR_WAIT  = 3'd5;
   localparam logic [2:0] S_FIN       = 3'd6;

   typedef struct packed {
      logic [DATA_W-1:0] v0;
      logic [DATA_W-1:0] v1;
   } pair_t;

endpackage

// File: rtl/imdct_overlap_sequencer_if.sv
// imdct_overlap_sequencer_if: windowed-pair input stream plus
// the command/response bus toward the overlap stage.
interface imdct_overlap_sequencer_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [17:0]       in_data_0;
   logic [17:0]       in_data_1;
   logic [ADDR_W-1:0] ov_base_address;
   logic [1:0]        ov_block_type;
   logic [17:0]       ov_value_0;
   logic [17:0]       ov_value_1;
   logic [5:0]        ov_index_0;
   logic [5:0]        ov_index_1;
   logic              ov_windowing_done;
   logic              ov_done;

   modport master (
      input  in_valid,
      input  in_data_0,
      input  in_data_1,
      input  ov_done,
      output in_ready,
      output ov_base_address,
      output ov_block_type,
      output ov_value_0,
      output ov_value_1,
      output ov_index_0,
      output ov_index_1,
      output ov_windowing_done
   );

   modport slave (
      output in_valid,
      output in_data_0,
      output in_data_1,
      output ov_done,
      input  in_ready,
      input  ov_base_address,
      input  ov_block_type,
      input  ov_value_0,
      input  ov_value_1,
      input  ov_index_0,
      input  ov_index_1,
      input  ov_windowing_done
   );
endinterface

// File: rtl/imdct_overlap_addr_gen.sv
// imdct_overlap_addr_gen: subband/pair counters for the sequencer.
// Derives subband base address and even/odd sample indices.
module imdct_overlap_addr_gen #(
   parameter int NUM_SB = imdct_pkg::NUM_SB,
   parameter int SB_LEN = imdct_pkg::SB_LEN,
   parameter int ADDR_W = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic                         step,
   input  logic                         half,
   output logic                         last_pair,
   output logic                         last_sb,
   output logic [ADDR_W-1:0]            base,
   output logic [imdct_pkg::IDX_W-1:0]  index_0,
   output logic [imdct_pkg::IDX_W-1:0]  index_1
);
   import imdct_pkg::*;

   localparam int SB_W = (NUM_SB > 1) ? $clog2(NUM_SB) : 1;
   localparam logic [PAIR_W-1:0] HALF = PAIR_W'(SB_LEN / 2);
   localparam logic [PAIR_W-1:0] LAST = PAIR_W'(SB_LEN - 1);
   localparam logic [SB_W-1:0] SB_LAST = SB_W'(NUM_SB - 1);

   logic [SB_W-1:0]   sb;
   logic [PAIR_W-1:0] pair;
   logic [ADDR_W-1:0] sb_ext;

   // half selects the second-half pair range used by the clear sweep
   always_ff @(posedge clk) begin
      if (rst) begin
         sb   <= '0;
         pair <= '0;
      end else if (load) begin
         sb   <= '0;
         pair <= half ? HALF : '0;
      end else if (step) begin
         if (last_pair) begin
            sb   <= sb + 1'b1;
            pair <= half ? HALF : '0;
         end else begin
            pair <= pair + 1'b1;
         end
      end
   end

   assign last_pair = (pair == LAST);
   assign last_sb   = (sb == SB_LAST);
   assign sb_ext    = ADDR_W'(sb);
   assign base      = (sb_ext << 4) + (sb_ext << 1);
   assign index_0   = {pair, 1'b0};
   assign index_1   = {pair, 1'b1};

endmodule

// File: rtl/imdct_overlap_sequencer.sv
// imdct_overlap_sequencer: drives the IMDCT overlap stage for one
// granule, or sweeps zeros through the overlap memory on clear.
module imdct_overlap_sequencer #(
   parameter int NUM_SB = imdct_pkg::NUM_SB,
   parameter int SB_LEN = imdct_pkg::SB_LEN,
   parameter int ADDR_W = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      clear,
   input  logic [1:0]                block_type_in,
   imdct_overlap_sequencer_if.master bus,
   output logic                      busy,
   output logic                      granule_done,
   output logic                      protocol_error
);
   import imdct_pkg::*;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_d;
   logic               load;
   logic               step;
   logic               half;
   logic               last_pair;
   logic               last_sb;
   logic               active;
   logic               waiting;
   pair_t              val;
   logic [1:0]         blk;
   logic               perr;
   logic [ADDR_W-1:0]  base;
   logic [IDX_W-1:0]   idx_0;
   logic [IDX_W-1:0]   idx_1;

   imdct_overlap_addr_gen #(
      .NUM_SB (NUM_SB),
      .SB_LEN (SB_LEN),
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .half      (half),
      .last_pair (last_pair),
      .last_sb   (last_sb),
      .base      (base),
      .index_0   (idx_0),
      .index_1   (idx_1)
   );

   // clear wins over start in IDLE; the start is dropped
   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      half    = (state == S_CLR_WAIT);
      case (state)
         S_IDLE: begin
            if (clear) begin
               state_d = S_CLR_ISSUE;
               load    = 1'b1;
               half    = 1'b1;
            end else if (start) begin
               state_d = S_WAIT_PAIR;
               load    = 1'b1;
            end
         end
         S_WAIT_PAIR: begin
            if (bus.in_valid) state_d = S_ISSUE;
         end
         S_ISSUE: state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (bus.ov_done) begin
               if (last_pair && last_sb) begin
                  state_d = S_FIN;
               end else begin
                  step    = 1'b1;
                  state_d = S_WAIT_PAIR;
               end
            end
         end
         S_CLR_ISSUE: state_d = S_CLR_WAIT;
         S_CLR_WAIT: begin
            if (bus.ov_done) begin
               if (last_pair && last_sb) begin
                  state_d = S_FIN;
               end else begin
                  step    = 1'b1;
                  state_d = S_CLR_ISSUE;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         val   <= '0;
         blk   <= BT_LONG;
         perr  <= 1'b0;
      end else begin
         state <= state_d;
         if (bus.ov_done && !waiting) perr <= 1'b1;
         if (state == S_IDLE && clear) begin
            val <= '0;
         end else if (state == S_IDLE && start) begin
            blk <= block_type_in;
         end else if (state == S_WAIT_PAIR && bus.in_valid) begin
            val <= {bus.in_data_0, bus.in_data_1};
         end
      end
   end

   assign active  = (state != S_IDLE);
   assign waiting = (state == S_WAIT_DONE) || (state == S_CLR_WAIT);

   assign bus.in_ready          = (state == S_WAIT_PAIR);
   assign bus.ov_windowing_done = (state == S_ISSUE) ||
                                  (state == S_CLR_ISSUE);
   assign bus.ov_base_address   = active ? base : '0;
   assign bus.ov_index_0        = active ? idx_0 : '0;
   assign bus.ov_index_1        = active ? idx_1 : '0;
   assign bus.ov_value_0        = val.v0;
   assign bus.ov_value_1        = val.v1;
   assign bus.ov_block_type     = blk;

   assign busy           = active;
   assign granule_done   = (state == S_FIN);
   assign protocol_error = perr;

endmodule

// File: tb/tb_imdct_overlap_sequencer.sv
// tb_imdct_overlap_sequencer: directed bench with an overlap-stage
// responder model, a pulse monitor and a table of pair vectors.
module tb_imdct_overlap_sequencer;
   import imdct_pkg::*;

   typedef struct {
      int n;
      int base;
      int i0;
      int i1;
      int v0;
      int v1;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] block_type_in = 2'b00;
   logic       busy;
   logic       granule_done;
   logic       protocol_error;
   logic       model_done = 1'b0;
   logic       inj_done = 1'b0;

   int pass_cnt = 0;
   int check_cnt = 0;

   int cyc = 0;
   int acc = 0;
   int first_hs = 0;
   int first_wd = 0;
   int npulse = 0;
   int mon_err = 0;
   int stab_err = 0;
   int dbl_err = 0;
   int gd_cnt = 0;
   int gd_cyc = 0;
   int mode = 0;
   int pend = 0;
   bit holding = 0;
   bit tbl_on = 0;
   logic [1:0] exp_bt = 2'b00;
   logic [59:0] snap = '0;
   vec_t tbl [7];

   imdct_overlap_sequencer_if #(.ADDR_W(10)) bus ();

   assign bus.ov_done = model_done | inj_done;

   imdct_overlap_sequencer #(
      .NUM_SB (32),
      .SB_LEN (18),
      .ADDR_W (10)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .clear          (clear),
      .block_type_in  (block_type_in),
      .bus            (bus),
      .busy           (busy),
      .granule_done   (granule_done),
      .protocol_error (protocol_error)
   );

   always #5 clk = ~clk;

   // overlap stage: done 4 cycles after an add pulse, 3 after a store
   always @(posedge clk) begin
      #1;
      model_done = 1'b0;
      if (rst) begin
         pend = 0;
      end else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) model_done = 1'b1;
         end
         if (bus.ov_windowing_done)
            pend = (bus.ov_index_0 < 6'd18) ? 4 : 3;
      end
   end

   task automatic check(input string name, input longint act,
                        input longint exp);
      check_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [59:0] ov_vec();
      return {bus.ov_base_address, bus.ov_block_type,
              bus.ov_value_0, bus.ov_value_1,
              bus.ov_index_0, bus.ov_index_1};
   endfunction

   task automatic on_pulse();
      int sb;
      int pr;
      int ev0;
      int ev1;
      if (mode == 0) begin
         sb  = npulse / 18;
         pr  = npulse % 18;
         ev0 = 2 * npulse;
         ev1 = ev0 + 1;
      end else begin
         sb  = npulse / 9;
         pr  = 9 + npulse % 9;
         ev0 = 0;
         ev1 = 0;
      end
      if (int'(bus.ov_base_address) != sb * 18 ||
          int'(bus.ov_index_0) != 2 * pr ||
          int'(bus.ov_index_1) != 2 * pr + 1 ||
          int'(bus.ov_value_0) != ev0 ||
          int'(bus.ov_value_1) != ev1)
         mon_err++;
      if (mode == 0 && bus.ov_block_type != exp_bt) mon_err++;
      if (tbl_on) begin
         for (int i = 0; i < 7; i++) begin
            if (tbl[i].n == npulse) begin
               check($sformatf("tbl%0d_base", i),
                     bus.ov_base_address, tbl[i].base);
               check($sformatf("tbl%0d_idx0", i),
                     bus.ov_index_0, tbl[i].i0);
               check($sformatf("tbl%0d_idx1", i),
                     bus.ov_index_1, tbl[i].i1);
               check($sformatf("tbl%0d_val0", i),
                     bus.ov_value_0, tbl[i].v0);
               check($sformatf("tbl%0d_val1", i),
                     bus.ov_value_1, tbl[i].v1);
            end
         end
      end
   endtask

   task automatic tick();
      logic hs;
      logic dn;
      @(negedge clk);
      hs = bus.in_valid & bus.in_ready;
      dn = bus.ov_done;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         if (acc == 0) first_hs = cyc - 1;
         acc++;
         bus.in_data_0 = 18'(2 * acc);
         bus.in_data_1 = 18'(2 * acc + 1);
      end
      if (dn) holding = 0;
      if (bus.ov_windowing_done) begin
         if (holding) dbl_err++;
         on_pulse();
         if (npulse == 0) first_wd = cyc;
         snap = ov_vec();
         holding = 1;
         npulse++;
      end else if (holding && ov_vec() != snap) begin
         stab_err++;
      end
      if (granule_done) begin
         gd_cnt++;
         gd_cyc = cyc;
      end
   endtask

   task automatic reset_mon(input int m);
      mode = m;
      acc = 0;
      npulse = 0;
      mon_err = 0;
      stab_err = 0;
      dbl_err = 0;
      gd_cnt = 0;
      holding = 0;
      bus.in_data_0 = 18'd0;
      bus.in_data_1 = 18'd1;
   endtask

   task automatic run_until_gd(input int limit, input string name);
      int n;
      n = 0;
      while (gd_cnt == 0 && n < limit) begin
         tick();
         n++;
      end
      check({name, "_gd_seen"}, (gd_cnt > 0), 1);
   endtask

   task automatic wait_pulses(input int target, input int limit,
                              input string name);
      int n;
      n = 0;
      while (npulse < target && n < limit) begin
         tick();
         n++;
      end
      check({name, "_pulse_reached"}, (npulse >= target), 1);
   endtask

   task automatic check_idle_zero(input string name);
      check({name, "_values"},
            {bus.ov_value_0, bus.ov_value_1}, 0);
      check({name, "_ctrl"},
            {bus.in_ready, bus.ov_base_address, bus.ov_block_type,
             bus.ov_index_0, bus.ov_index_1, bus.ov_windowing_done,
             busy, granule_done, protocol_error}, 0);
   endtask

   initial begin
      int n;
      tbl[0] = '{0,   0,   0,  1,    0,    1};
      tbl[1] = '{8,   0,  16, 17,   16,   17};
      tbl[2] = '{9,   0,  18, 19,   18,   19};
      tbl[3] = '{17,  0,  34, 35,   34,   35};
      tbl[4] = '{18, 18,   0,  1,   36,   37};
      tbl[5] = '{93, 90,   6,  7,  186,  187};
      tbl[6] = '{575, 558, 34, 35, 1150, 1151};

      bus.in_valid = 1'b0;
      reset_mon(0);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_idle_zero("reset");

      // abort mid-granule at sb=5, pair=3
      reset_mon(0);
      block_type_in = BT_SHORT;
      exp_bt = BT_SHORT;
      bus.in_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_pulses(94, 1000, "midrst");
      check("midrst_mon_err", mon_err, 0);
      rst = 1'b1;
      tick();
      holding = 0;
      check_idle_zero("midrst");
      rst = 1'b0;
      bus.in_valid = 1'b0;
      repeat (20) tick();
      check("midrst_no_gd", gd_cnt, 0);

      // full granule, in_valid held high, block type latched
      reset_mon(0);
      tbl_on = 1;
      bus.in_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      block_type_in = BT_LONG;
      check("start_in_ready", bus.in_ready, 1);
      run_until_gd(4000, "full");
      tbl_on = 0;
      check("full_gd_cycle", gd_cyc - first_hs, 3168);
      repeat (5) tick();
      check("full_pulses", npulse, 576);
      check("full_gd_once", gd_cnt, 1);
      check("full_mon_err", mon_err, 0);
      check("full_stable_err", stab_err, 0);
      check("full_double_issue", dbl_err, 0);
      check("full_no_perr", protocol_error, 0);
      check("full_idle", busy, 0);

      // start and clear together: clear sweep only
      reset_mon(1);
      bus.in_valid = 1'b0;
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      run_until_gd(1500, "clr");
      check("clr_gd_cycle", gd_cyc - first_wd, 1152);
      repeat (10) tick();
      check("clr_pulses", npulse, 288);
      check("clr_mon_err", mon_err, 0);
      check("clr_double_issue", dbl_err, 0);
      check("clr_gd_once", gd_cnt, 1);
      check("clr_start_dropped", busy, 0);

      // granule with a 10-cycle input stall before pair 4
      reset_mon(0);
      block_type_in = BT_LONG;
      exp_bt = BT_LONG;
      bus.in_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (acc < 4 && n < 100) begin
         tick();
         n++;
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("stall_ready", bus.in_ready, 1);
      snap = ov_vec();
      n = npulse;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ov_vec() != snap) stab_err++;
      end
      check("stall_no_pulse", npulse, n);
      check("stall_hold_err", stab_err, 0);
      bus.in_valid = 1'b1;
      wait_pulses(5, 20, "resume");
      check("resume_idx0", bus.ov_index_0, 8);
      check("resume_idx1", bus.ov_index_1, 9);
      run_until_gd(4000, "stall");
      check("stall_pulses", npulse, 576);
      check("stall_mon_err", mon_err, 0);
      check("stall_stable_err", stab_err, 0);
      check("stall_double_issue", dbl_err, 0);

      // stray ov_done in WAIT_PAIR latches protocol_error
      reset_mon(0);
      bus.in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("perr_before", protocol_error, 0);
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      check("perr_set", protocol_error, 1);
      repeat (5) tick();
      check("perr_sticky", protocol_error, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("perr_cleared", protocol_error, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/imdct_overlap_sequencer.md
# imdct_overlap_sequencer

Controller that drives the IMDCT `overlap` stage for one granule of one channel. It accepts windowed sample pairs from the windowing stage over a valid/ready handshake. For each pair it generates `base_address`, `index_0`/`index_1` and a single-cycle `windowing_done` pulse, then waits for the stage's `done` before issuing the next pair. A clear command zeroes the overlap memory by replaying second-half writes with zero data.

## Interface
Parameters:
- NUM_SB, 32, subbands per granule
- SB_LEN, 18, overlap entries per subband (half of 36-sample window)
- ADDR_W, 10, overlap memory address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse: begin one granule
- clear  in  1  pulse: zero overlap memory
- block_type_in  in  2  block type, sampled on accepted start
- in_valid  in  1  windowed pair available
- in_ready  out  1  sequencer accepts pair
- in_data_0  in  18  sample at even index
- in_data_1  in  18  sample at odd index
- ov_base_address  out  ADDR_W  subband base = sb*18
- ov_block_type  out  2  latched block type
- ov_value_0  out  18  held sample 0
- ov_value_1  out  18  held sample 1
- ov_index_0  out  6  2*pair
- ov_index_1  out  6  2*pair+1
- ov_windowing_done  out  1  one-cycle issue pulse
- ov_done  in  1  overlap stage finished pair
- busy  out  1  not IDLE
- granule_done  out  1  one-cycle pulse after last pair of granule or clear
- protocol_error  out  1  sticky: ov_done seen outside wait states

## Operation
- Counters: sb 0..NUM_SB-1, pair 0..17.
- Pairs per subband arrive in order (0,1),(2,3)…(34,35):
  - pairs 0–8 are overlap-add (index<18);
  - pairs 9–17 are stored to memory.
- ov_base_address = (sb<<4)+(sb<<1), computed combinationally from sb.
- States:
  - IDLE: clear has priority over start. If both are asserted, start is dropped and not queued. clear → CLR_ISSUE with sb=0, pair=9. start → WAIT_PAIR with sb=0, pair=0; latch block_type_in.
  - WAIT_PAIR: in_ready=1. On in_valid, latch in_data_0/1 into ov_value_0/1 → ISSUE.
  - ISSUE: ov_windowing_done=1 for exactly one cycle → WAIT_DONE.
  - WAIT_DONE: on ov_done, advance.
    - pair<17: pair+1 → WAIT_PAIR.
    - pair=17, sb<NUM_SB-1: pair=0, sb+1 → WAIT_PAIR.
    - pair=17, sb=NUM_SB-1: → FIN.
  - CLR_ISSUE: ov_value_0/1=0, ov_windowing_done=1 → CLR_WAIT.
  - CLR_WAIT: on ov_done, advance.
    - pair<17: pair+1 → CLR_ISSUE.
    - pair=17: pair=9, sb+1 → CLR_ISSUE.
    - last subband: → FIN.
  - FIN: granule_done=1 → IDLE.
- ov_value_*, ov_index_*, ov_base_address and ov_block_type are held constant from ISSUE until ov_done is seen.
- start, clear and in_valid are ignored while busy; in_ready stays 0 outside WAIT_PAIR.
- ov_done in IDLE, WAIT_PAIR, ISSUE, CLR_ISSUE or FIN sets protocol_error. It is cleared only by rst.

## Timing
- Reset values: all outputs 0, state IDLE, sb=0, pair=0, latched values 0. rst mid-operation aborts immediately and emits no granule_done. The overlap stage shares rst.
- First-half pair:
  - handshake at cycle A;
  - ov_windowing_done at A+1;
  - overlap sequence read_mem/calc_write_read/calc_write at A+2..A+4;
  - ov_done at A+5;
  - in_ready at A+6.
  - Period 6 cycles.
- Second-half pair: ov_done at A+4, period 5 cycles.
- Granule with in_valid held high: 32*(9*6+9*5)=3168 cycles from first handshake to granule_done. start is accepted at cycle S, and in_ready is first high at S+1.
- Clear: 4 cycles per pair, 288 pairs, granule_done 1152 cycles after the first CLR_ISSUE.
- Never two ov_windowing_done pulses without an intervening ov_done.

## Structure
- Package imdct_pkg: NUM_SB, SB_LEN, state encoding, block-type constants (long=2'b00, short=2'b10).
- Sub-module imdct_overlap_addr_gen holds the sb/pair counters and derives base and indices.
- FSM and data registers stay in the top module.

## Test plan
- Reset mid-granule (sb=5, pair=3):
  - all outputs 0 next cycle;
  - no granule_done;
  - new start runs a full granule.
- Single granule, in_valid always 1, in_data_0=k, in_data_1=k+1:
  - 576 ov_windowing_done pulses;
  - pair (sb=31, pair=17) drives base=558, index 34/35;
  - granule_done at cycle 3168.
- Stalled input: in_valid low 10 cycles before pair 4:
  - ov_* stable throughout;
  - no extra ov_windowing_done;
  - index 8/9 issued after resume.
- Clear then granule:
  - 288 ov_windowing_done pulses, indices 18..35 only, values 0;
  - subsequent granule outputs equal the windowed input with nothing added.
- start and clear asserted together in IDLE:
  - clear executes;
  - start is not queued;
  - granule_done fires once.
- ov_done injected while in WAIT_PAIR: protocol_error=1 and stays 1 until rst.
